// File: rtl/outlier_drain_pkg.sv
// Shared state encoding, settle timing and helpers for the outlier drain block.
// The optional range check is enabled by defining OUTLIER_RANGE_CHECK_EN.
package outlier_drain_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SETTLE = 2'd1,
        FLUSH  = 2'd2,
        DONE   = 2'd3
    } drain_state_t;

    // Cycles spent in SETTLE so a late fifo_empty deassertion is still seen.
    localparam int unsigned SETTLE_CYCLES = 2;
    localparam int          SETTLE_CNT_W  = $clog2(SETTLE_CYCLES) + 1;

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/drain_skid_fifo.sv
// Small circular skid buffer holding outlier positions between the source
// FIFO read port and the downstream stream; pointers wrap modulo DEPTH.
module drain_skid_fifo
    import outlier_drain_pkg::*;
#(
    parameter int W     = 16,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [CW-1:0] count,
    output logic [W-1:0]  head
);

    if (DEPTH < 3 || !is_pow2(DEPTH)) begin : g_bad_depth
        $error("drain_skid_fifo: DEPTH must be a power of two and at least 3");
    end

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          push_ok;
    logic          pop_ok;

    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign pop_ok  = pop && (count_q != '0);
    assign push_ok = push && ((count_q != CW'(DEPTH)) || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/outlier_drain.sv
// Drains outlier positions from a FIFO into a valid/ready stream, marking the
// final beat. Define OUTLIER_RANGE_CHECK_EN to drop positions >= point_cloud_size.
module outlier_drain
    import outlier_drain_pkg::*;
#(
    parameter int N         = 16,
    parameter int BUF_DEPTH = 4
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [N-1:0]   fifo_dout,
    input  logic           fifo_empty,
    output logic           fifo_rd_en,
    input  logic           ctrl_done,
    input  logic [2*N-1:0] point_cloud_size,
    output logic           m_valid,
    input  logic           m_ready,
    output logic [N-1:0]   m_pos,
    output logic           m_last,
    output logic [N-1:0]   outlier_count,
    output logic           range_error,
    output logic           drain_done
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;
    localparam logic [CW:0] OCC_LIMIT = BUF_DEPTH[CW:0];
    localparam logic [SETTLE_CNT_W-1:0] SETTLE_LAST = SETTLE_CNT_W'(SETTLE_CYCLES - 1);

    drain_state_t            state_q, state_d;
    logic [SETTLE_CNT_W-1:0] settle_cnt_q, settle_cnt_d;
    logic                    rd_pend_q, rd_pend_d;
    logic [N-1:0]            outlier_count_q, outlier_count_d;
    logic                    range_error_q, range_error_d;
    logic                    drain_done_q, drain_done_d;

    logic [CW-1:0] buf_count;
    logic [N-1:0]  buf_head;
    logic [CW:0]   occ;
    logic          pos_ok;
    logic          push;
    logic          pop;

    function automatic logic [N-1:0] sat_inc(input logic [N-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

`ifdef OUTLIER_RANGE_CHECK_EN
    assign pos_ok = ({{N{1'b0}}, fifo_dout} < point_cloud_size);
`else
    logic unused_size;
    assign unused_size = ^point_cloud_size;
    assign pos_ok      = 1'b1;
`endif

    assign push = rd_pend_q && pos_ok;
    assign pop  = m_valid && m_ready;

    drain_skid_fifo #(
        .W     (N),
        .DEPTH (BUF_DEPTH)
    ) u_skid (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (fifo_dout),
        .pop       (pop),
        .count     (buf_count),
        .head      (buf_head)
    );

    // Read credit: an in-flight read already owns a buffer slot.
    assign occ = {1'b0, buf_count} + {{CW{1'b0}}, rd_pend_q};

    always_comb begin
        fifo_rd_en = !reset && !fifo_empty && (state_q != DONE) && (occ < OCC_LIMIT);
    end

    // Before FLUSH the last buffered entry is held back so its m_last can be decided.
    always_comb begin
        m_valid = 1'b0;
        case (state_q)
            RUN, SETTLE: m_valid = (buf_count >= CW'(2)) ||
                                   ((buf_count == CW'(1)) && rd_pend_q);
            FLUSH:       m_valid = (buf_count != '0);
            default:     m_valid = 1'b0;
        endcase
        m_last = (state_q == FLUSH) && (buf_count == CW'(1)) && !rd_pend_q && fifo_empty;
        m_pos  = m_valid ? buf_head : '0;
    end

    always_comb begin
        state_d         = state_q;
        settle_cnt_d    = settle_cnt_q;
        rd_pend_d       = fifo_rd_en;
        outlier_count_d = pop ? sat_inc(outlier_count_q) : outlier_count_q;
        range_error_d   = range_error_q || (rd_pend_q && !pos_ok);
        case (state_q)
            RUN: begin
                if (ctrl_done) begin
                    state_d      = SETTLE;
                    settle_cnt_d = '0;
                end
            end
            SETTLE: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    state_d = FLUSH;
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end
            FLUSH: begin
                if (fifo_empty && !rd_pend_q && (buf_count == '0)) begin
                    state_d = DONE;
                end
            end
            default: state_d = DONE;
        endcase
        drain_done_d = (state_d == DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= RUN;
            settle_cnt_q    <= '0;
            rd_pend_q       <= 1'b0;
            outlier_count_q <= '0;
            range_error_q   <= 1'b0;
            drain_done_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            settle_cnt_q    <= settle_cnt_d;
            rd_pend_q       <= rd_pend_d;
            outlier_count_q <= outlier_count_d;
            range_error_q   <= range_error_d;
            drain_done_q    <= drain_done_d;
        end
    end

    assign outlier_count = outlier_count_q;
    assign range_error   = range_error_q;
    assign drain_done    = drain_done_q;

endmodule

// File: tb/tb_outlier_drain.sv
// Directed bench for outlier_drain: FIFO model, beat recorder, one task per scenario.
`timescale 1ns/1ps
module tb_outlier_drain;

    localparam int N         = 16;
    localparam int BUF_DEPTH = 4;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   fifo_dout = '0;
    logic           fifo_empty = 1'b1;
    logic           fifo_rd_en;
    logic           ctrl_done = 1'b0;
    logic [2*N-1:0] point_cloud_size = 32'd1000;
    logic           m_valid;
    logic           m_ready = 1'b0;
    logic [N-1:0]   m_pos;
    logic           m_last;
    logic [N-1:0]   outlier_count;
    logic           range_error;
    logic           drain_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rd_issued = 0;
    int beats_done = 0;

    logic [N-1:0] fq[$];
    logic [N-1:0] beat_pos[$];
    logic         beat_last[$];
    int           beat_cyc[$];

    outlier_drain #(
        .N         (N),
        .BUF_DEPTH (BUF_DEPTH)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .fifo_dout        (fifo_dout),
        .fifo_empty       (fifo_empty),
        .fifo_rd_en       (fifo_rd_en),
        .ctrl_done        (ctrl_done),
        .point_cloud_size (point_cloud_size),
        .m_valid          (m_valid),
        .m_ready          (m_ready),
        .m_pos            (m_pos),
        .m_last           (m_last),
        .outlier_count    (outlier_count),
        .range_error      (range_error),
        .drain_done       (drain_done)
    );

    always #5 clock = ~clock;

    // Source FIFO: data one cycle after rd_en, empty flag lags a push by one cycle.
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (reset) begin
            fq.delete();
            fifo_empty <= 1'b1;
        end else begin
            if (fifo_rd_en && fq.size() > 0) begin
                fifo_dout <= fq.pop_front();
            end
            fifo_empty <= (fq.size() == 0);
        end
    end

    // Records handshakes and reads that the next rising edge will commit.
    always @(negedge clock) begin
        if (reset) begin
            rd_issued  = 0;
            beats_done = 0;
            beat_pos.delete();
            beat_last.delete();
            beat_cyc.delete();
        end else begin
            if (fifo_rd_en) rd_issued++;
            if (m_valid && m_ready) begin
                beats_done++;
                beat_pos.push_back(m_pos);
                beat_last.push_back(m_last);
                beat_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ctrl_done = 1'b0;
        m_ready = 1'b0;
        point_cloud_size = 32'd1000;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_done(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (drain_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [5:0] flags;
        reset = 1'b1;
        tick();
        tick();
        flags = {m_valid, m_last, range_error, drain_done, fifo_rd_en, (m_pos != '0)};
        checks++;
        if (flags !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got %b exp 000000", flags);
        end
        checks++;
        if (outlier_count !== '0) begin
            errors++;
            $display("FAIL reset_count got %0d exp 0", outlier_count);
        end
    endtask

    task automatic test_basic();
        logic [N-1:0] exp[$];
        bit ok;
        exp = '{16'd5, 16'd9, 16'd12};
        do_reset();
        foreach (exp[i]) fq.push_back(exp[i]);
        m_ready = 1'b1;
        tick();
        ctrl_done = 1'b1;
        wait_done(60, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL basic_done got timeout exp drain_done");
        end
        checks++;
        if (beat_pos.size() != exp.size()) begin
            errors++;
            $display("FAIL basic_beats got %0d exp %0d", beat_pos.size(), exp.size());
        end
        foreach (exp[i]) begin
            checks++;
            if (i >= beat_pos.size() || beat_pos[i] !== exp[i] ||
                beat_last[i] !== (i == exp.size() - 1)) begin
                errors++;
                $display("FAIL basic_beat%0d got %0d/%0b exp %0d/%0b", i,
                         (i < beat_pos.size()) ? beat_pos[i] : 16'hxxxx,
                         (i < beat_pos.size()) ? beat_last[i] : 1'bx,
                         exp[i], (i == exp.size() - 1));
            end
        end
        checks++;
        if (outlier_count !== 16'd3) begin
            errors++;
            $display("FAIL basic_count got %0d exp 3", outlier_count);
        end
        checks++;
        if (m_valid !== 1'b0 || fifo_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle got valid=%0b rd=%0b exp 0/0", m_valid, fifo_rd_en);
        end
    endtask

    task automatic test_zero();
        int n;
        bit seen_valid;
        do_reset();
        ctrl_done = 1'b1;
        n = 0;
        seen_valid = 1'b0;
        while (n < 20) begin
            tick();
            n++;
            if (m_valid) seen_valid = 1'b1;
            if (drain_done) break;
        end
        checks++;
        if (!drain_done || n < 4 || n > 8) begin
            errors++;
            $display("FAIL zero_latency got done=%0b after %0d edges exp done within 4..8", drain_done, n);
        end
        checks++;
        if (seen_valid || beat_pos.size() != 0) begin
            errors++;
            $display("FAIL zero_beats got valid=%0b beats=%0d exp 0/0", seen_valid, beat_pos.size());
        end
        checks++;
        if (outlier_count !== '0) begin
            errors++;
            $display("FAIL zero_count got %0d exp 0", outlier_count);
        end
    endtask

    task automatic test_stream100();
        bit ok;
        int gaps;
        logic [N-1:0] v;
        do_reset();
        for (int i = 0; i < 100; i++) fq.push_back(16'(i * 7 + 3));
        m_ready = 1'b1;
        ctrl_done = 1'b1;
        wait_done(400, ok);
        checks++;
        if (!ok || beat_pos.size() != 100) begin
            errors++;
            $display("FAIL stream_beats got done=%0b beats=%0d exp 1/100", ok, beat_pos.size());
        end
        for (int i = 0; i < 100; i++) begin
            v = 16'(i * 7 + 3);
            checks++;
            if (i >= beat_pos.size() || beat_pos[i] !== v || beat_last[i] !== (i == 99)) begin
                errors++;
                $display("FAIL stream_beat%0d got %0d exp %0d", i,
                         (i < beat_pos.size()) ? beat_pos[i] : 16'hxxxx, v);
            end
        end
        gaps = 0;
        for (int i = 1; i < beat_cyc.size(); i++) begin
            if (beat_cyc[i] - beat_cyc[i-1] != 1) gaps++;
        end
        checks++;
        if (gaps != 0) begin
            errors++;
            $display("FAIL stream_gaps got %0d exp 0", gaps);
        end
        checks++;
        if (outlier_count !== 16'd100) begin
            errors++;
            $display("FAIL stream_count got %0d exp 100", outlier_count);
        end
    endtask

    task automatic test_stall();
        logic [3:0]   pat = 4'b1001;
        logic         prev_valid, prev_ready;
        logic [N-1:0] prev_pos;
        logic [N-1:0] v;
        int occ;
        int k;
        do_reset();
        for (int i = 0; i < 8; i++) fq.push_back(16'(20 + i));
        repeat (8) tick();
        occ = rd_issued - beats_done;
        checks++;
        if (occ != 4 || fifo_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL stall_credit got occ=%0d rd=%0b exp 4/0", occ, fifo_rd_en);
        end
        checks++;
        if (m_valid !== 1'b1 || m_pos !== 16'd20) begin
            errors++;
            $display("FAIL stall_head got %0b/%0d exp 1/20", m_valid, m_pos);
        end
        prev_valid = m_valid;
        prev_ready = m_ready;
        prev_pos   = m_pos;
        ctrl_done  = 1'b1;
        k = 0;
        while (!drain_done && k < 80) begin
            m_ready = pat[k % 4];
            prev_ready = m_ready;
            prev_valid = m_valid;
            prev_pos   = m_pos;
            tick();
            k++;
            if (prev_valid && !prev_ready) begin
                checks++;
                if (m_valid !== 1'b1 || m_pos !== prev_pos) begin
                    errors++;
                    $display("FAIL stall_hold got %0b/%0d exp 1/%0d", m_valid, m_pos, prev_pos);
                end
            end
            occ = rd_issued - beats_done;
            checks++;
            if (occ > 4 || (fifo_rd_en && occ >= 4)) begin
                errors++;
                $display("FAIL stall_occ got occ=%0d rd=%0b exp occ<=4 and no read at 4", occ, fifo_rd_en);
            end
        end
        checks++;
        if (!drain_done || beat_pos.size() != 8) begin
            errors++;
            $display("FAIL stall_beats got done=%0b beats=%0d exp 1/8", drain_done, beat_pos.size());
        end
        for (int i = 0; i < 8; i++) begin
            v = 16'(20 + i);
            checks++;
            if (i >= beat_pos.size() || beat_pos[i] !== v || beat_last[i] !== (i == 7)) begin
                errors++;
                $display("FAIL stall_beat%0d got %0d exp %0d", i,
                         (i < beat_pos.size()) ? beat_pos[i] : 16'hxxxx, v);
            end
        end
        checks++;
        if (outlier_count !== 16'd8) begin
            errors++;
            $display("FAIL stall_count got %0d exp 8", outlier_count);
        end
    endtask

    task automatic test_range();
        logic [N-1:0] exp[$];
        logic         exp_err;
        bit ok;
`ifdef OUTLIER_RANGE_CHECK_EN
        exp = '{16'd3, 16'd7};
        exp_err = 1'b1;
`else
        exp = '{16'd3, 16'd15, 16'd7};
        exp_err = 1'b0;
`endif
        do_reset();
        point_cloud_size = 32'd10;
        fq.push_back(16'd3);
        fq.push_back(16'd15);
        fq.push_back(16'd7);
        m_ready = 1'b1;
        tick();
        ctrl_done = 1'b1;
        wait_done(60, ok);
        checks++;
        if (!ok || beat_pos.size() != exp.size()) begin
            errors++;
            $display("FAIL range_beats got done=%0b beats=%0d exp 1/%0d", ok, beat_pos.size(), exp.size());
        end
        foreach (exp[i]) begin
            checks++;
            if (i >= beat_pos.size() || beat_pos[i] !== exp[i] ||
                beat_last[i] !== (i == exp.size() - 1)) begin
                errors++;
                $display("FAIL range_beat%0d got %0d exp %0d", i,
                         (i < beat_pos.size()) ? beat_pos[i] : 16'hxxxx, exp[i]);
            end
        end
        checks++;
        if (range_error !== exp_err) begin
            errors++;
            $display("FAIL range_flag got %0b exp %0b", range_error, exp_err);
        end
        checks++;
        if (outlier_count !== 16'(exp.size())) begin
            errors++;
            $display("FAIL range_count got %0d exp %0d", outlier_count, exp.size());
        end
    endtask

    task automatic test_midreset();
        bit ok;
        do_reset();
        fq.push_back(16'd10);
        fq.push_back(16'd11);
        fq.push_back(16'd12);
        repeat (6) tick();
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        checks++;
        if (m_valid !== 1'b1 || m_pos !== 16'd11 || outlier_count !== 16'd1) begin
            errors++;
            $display("FAIL midrst_pre got %0b/%0d/%0d exp 1/11/1", m_valid, m_pos, outlier_count);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (m_valid !== 1'b0 || m_pos !== '0 || outlier_count !== '0 ||
            drain_done !== 1'b0 || fifo_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL midrst_state got v=%0b pos=%0d cnt=%0d done=%0b rd=%0b exp all 0",
                     m_valid, m_pos, outlier_count, drain_done, fifo_rd_en);
        end
        reset = 1'b0;
        m_ready = 1'b1;
        tick();
        checks++;
        if (m_valid !== 1'b0 || drain_done !== 1'b0) begin
            errors++;
            $display("FAIL midrst_run got v=%0b done=%0b exp 0/0", m_valid, drain_done);
        end
        ctrl_done = 1'b1;
        wait_done(30, ok);
        checks++;
        if (!ok || beat_pos.size() != 0 || outlier_count !== '0) begin
            errors++;
            $display("FAIL midrst_discard got done=%0b beats=%0d cnt=%0d exp 1/0/0",
                     ok, beat_pos.size(), outlier_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_stream100();
        test_stall();
        test_range();
        test_midreset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/outlier_drain.md
OUTLIER_DRAIN -- requirements
Module: outlier_drain

Interface
REQ-001 SHALL have parameter N, default 16, meaning the point-index width.
REQ-002 SHALL have parameter BUF_DEPTH, default 4, meaning the skid-buffer entries; it SHALL be a power of two and at least 3.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port fifo_dout, input, N bits: outlier position from the outlier FIFO, valid one cycle after fifo_rd_en.
REQ-006 SHALL have port fifo_empty, input, 1 bit: outlier FIFO empty.
REQ-007 SHALL have port fifo_rd_en, output, 1 bit: outlier FIFO pop request.
REQ-008 SHALL have port ctrl_done, input, 1 bit: the validation controller has finished.
REQ-009 SHALL have port point_cloud_size, input, 2N bits: number of points in the cloud.
REQ-010 SHALL have ports m_valid (output, 1), m_ready (input, 1), m_pos (output, N) and m_last (output, 1): the outlier stream.
REQ-011 SHALL have port outlier_count, output, N bits: number of beats accepted downstream.
REQ-012 SHALL have port range_error, output, 1 bit: sticky flag for an out-of-range position.
REQ-013 SHALL have port drain_done, output, 1 bit: all outliers have been delivered.

Function
REQ-014 SHALL assert fifo_rd_en only when !fifo_empty, the state is not DONE, and (buffer count + read-pending) < BUF_DEPTH.
REQ-015 SHALL set rd_pend one cycle after fifo_rd_en, and SHALL capture fifo_dout into the buffer tail in the cycle rd_pend is 1.
REQ-016 SHALL drive m_pos from the buffer head, in FIFO order, with no reordering or deduplication.
REQ-017 SHALL complete a beat when m_valid && m_ready; then it SHALL pop the head, and outlier_count SHALL increment, saturating at 2^N-1.
REQ-018 SHALL hold m_pos and m_last stable while m_valid && !m_ready.
REQ-019 SHALL use the FSM states RUN, SETTLE, FLUSH and DONE.
REQ-020 In RUN, on ctrl_done=1 the FSM SHALL go to SETTLE; ctrl_done is sampled only in RUN.
REQ-021 SETTLE SHALL last exactly 2 cycles, to cover FIFO empty-flag latency, and SHALL then go to FLUSH.
REQ-022 In FLUSH, when fifo_empty && !rd_pend && buffer count==0, the FSM SHALL go to DONE.
REQ-023 DONE SHALL hold until reset.
REQ-024 In RUN and SETTLE, m_valid SHALL be asserted only if count>=2, or count==1 && rd_pend; one entry is held back so that the final beat can be marked.
REQ-025 In FLUSH, m_valid SHALL be asserted whenever count>=1.
REQ-026 SHALL assert m_last only in FLUSH, with m_valid, when count==1 && !rd_pend && fifo_empty.
REQ-027 SHALL assert drain_done only in DONE.
REQ-028 If there are zero outliers, the block SHALL emit no beats and SHALL still reach DONE.
REQ-029 When a pop and a capture occur in the same cycle, count SHALL be unchanged; the buffer pointers SHALL wrap modulo BUF_DEPTH.
REQ-030 SHALL sustain one beat per cycle when m_ready is held at 1 and the FIFO is non-empty.

Reset
REQ-031 On reset: state=RUN, count=0, rd_pend=0, fifo_rd_en=0, m_valid=0, m_last=0, m_pos=0, outlier_count=0, range_error=0, drain_done=0.
REQ-032 A reset mid-stream SHALL discard the buffered entries and any pending read data.

Configuration
REQ-033 With OUTLIER_RANGE_CHECK_EN defined, a captured position >= point_cloud_size (compared zero-extended to 2N bits) SHALL be dropped and not buffered, and range_error SHALL set and stay set until reset.
REQ-034 Without OUTLIER_RANGE_CHECK_EN, every position SHALL be forwarded and range_error SHALL be tied to 0.

Structure
REQ-035 The state encoding (drain_state_t) and the SETTLE_CYCLES=2 constant SHALL live in the shared package.
REQ-036 The skid buffer SHALL be a sub-module named drain_skid_fifo (push, pop, count, head data); the FSM and read-credit logic SHALL stay in outlier_drain.

Verification
REQ-037 FIFO holds 5,9,12; ctrl_done asserted after the last write; m_ready=1 -> beats 5,9,12 with m_last on 12 only, outlier_count=3, then drain_done.
REQ-038 Zero outliers, ctrl_done=1 -> no m_valid, drain_done asserts 3 cycles after ctrl_done at the earliest, outlier_count=0.
REQ-039 FIFO holds 100 entries, m_ready=1 -> 100 beats in 100 consecutive cycles once streaming, no gaps.
REQ-040 m_ready toggling 1,0,0,1 during a stream -> m_pos stable while stalled, fifo_rd_en stops when count+rd_pend=4, no loss or duplication.
REQ-041 OUTLIER_RANGE_CHECK_EN defined, point_cloud_size=10, FIFO holds 3,15,7 -> beats 3,7 with m_last on 7, range_error=1; with the macro undefined -> beats 3,15,7, range_error=0.
REQ-042 Reset asserted with 2 entries buffered -> next cycle m_valid=0, count=0, outlier_count=0, state RUN.
